// File: rtl/instruction_fetcher_if.sv
// instruction_fetcher_if: fetch-stage bus (mem request/response, IFQ head to decoder, RoB redirect); master = fetcher, slave = memory/decoder/RoB side
interface instruction_fetcher_if #(parameter int ADDR_WIDTH = 32);
  logic mem_req_valid;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic mem_req_ready;
  logic mem_resp_valid;
  logic [31:0] mem_resp_inst;
  logic out_valid;
  logic [31:0] out_inst;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [ADDR_WIDTH-1:0] out_pred_pc;
  logic out_ready;
  logic redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  modport master (
    output mem_req_valid, mem_req_addr, out_valid, out_inst, out_pc, out_pred_pc,
    input mem_req_ready, mem_resp_valid, mem_resp_inst, out_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input mem_req_valid, mem_req_addr, out_valid, out_inst, out_pc, out_pred_pc,
    output mem_req_ready, mem_resp_valid, mem_resp_inst, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: fetch PC + single outstanding word request + IFQ to decoder; ports clk_in/rst_in(sync, active-high)/rdy_in(global stall) + bus (instruction_fetcher_if.master: mem req/resp, IFQ head valid/ready, redirect); define JAL_PREDICT_EN to follow JAL targets
module instruction_fetcher #(
  parameter int ADDR_WIDTH = 32,
  parameter int IFQ_WIDTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  instruction_fetcher_if.master bus
);
  localparam int DEPTH = 1 << IFQ_WIDTH;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
  state_t r_state, w_state_nx;
  logic [ADDR_WIDTH-1:0] r_fetch_pc, w_next_pc;
  logic [IFQ_WIDTH:0] r_count;
  logic [IFQ_WIDTH-1:0] r_head, r_tail;
  logic [31:0] r_inst [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pred [DEPTH];
  logic w_push, w_pop, w_busy;
`ifdef JAL_PREDICT_EN
  logic [20:0] w_jal_imm;
  assign w_jal_imm = {bus.mem_resp_inst[31], bus.mem_resp_inst[19:12], bus.mem_resp_inst[20], bus.mem_resp_inst[30:21], 1'b0};
  assign w_next_pc = r_fetch_pc + ((bus.mem_resp_inst[6:0] == 7'b1101111) ? {{(ADDR_WIDTH-21){w_jal_imm[20]}}, w_jal_imm} : ADDR_WIDTH'(4));
`else
  assign w_next_pc = r_fetch_pc + ADDR_WIDTH'(4);
`endif
  assign w_pop = bus.out_valid & bus.out_ready;
  assign w_push = (r_state == WAIT) & bus.mem_resp_valid & ~bus.redirect_valid;
  // a request is still owed a response after this edge; a redirect must then drain it in DROP
  assign w_busy = ((r_state == REQ) & bus.mem_req_ready) | (((r_state == WAIT) | (r_state == DROP)) & ~bus.mem_resp_valid);
  assign bus.mem_req_valid = r_state == REQ;
  assign bus.mem_req_addr = r_fetch_pc;
  assign bus.out_valid = r_count != '0;
  assign bus.out_inst = r_inst[r_head];
  assign bus.out_pc = r_pc[r_head];
  assign bus.out_pred_pc = r_pred[r_head];
  // count never exceeds DEPTH, so its MSB clear means a free slot for the next fetch
  always_comb begin
    w_state_nx = r_state;
    if (bus.redirect_valid)
      w_state_nx = w_busy ? DROP : IDLE;
    else
      w_state_nx = (r_state == IDLE) ? (r_count[IFQ_WIDTH] ? IDLE : REQ) :
                   (r_state == REQ) ? (bus.mem_req_ready ? WAIT : REQ) :
                   (bus.mem_resp_valid ? IDLE : r_state);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_count <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else if (rdy_in) begin
      r_state <= w_state_nx;
      if (bus.redirect_valid) begin
        r_fetch_pc <= bus.redirect_pc & ~ADDR_WIDTH'(3);
        r_count <= '0;
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) begin
          r_fetch_pc <= w_next_pc;
          r_tail <= r_tail + IFQ_WIDTH'(1);
        end
        if (w_pop) r_head <= r_head + IFQ_WIDTH'(1);
        r_count <= r_count + (IFQ_WIDTH+1)'(w_push) - (IFQ_WIDTH+1)'(w_pop);
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && w_push) begin
      r_inst[r_tail] <= bus.mem_resp_inst;
      r_pc[r_tail] <= r_fetch_pc;
      r_pred[r_tail] <= w_next_pc;
    end
  end
endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: randomized and directed checks of instruction_fetcher against a queue-level model of the fetch stream
module tb_instruction_fetcher;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pred;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  instruction_fetcher_if #(.ADDR_WIDTH(32)) bus();
  instruction_fetcher #(.ADDR_WIDTH(32), .IFQ_WIDTH(2), .RESET_PC(32'h0)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .bus(bus)
  );
  always #5 clk = ~clk;
  ent_t q[$];
  logic [31:0] exp_fetch, pend_addr, prev_ra, prev_pc, prev_pred, prev_inst;
  logic prev_ov, prev_rv;
  bit pending, stale, prev_hold, prev_redir, prev_frozen;
  int lat, lat_lo, lat_hi;
  int total = 0;
  int bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h20) ? 32'h0100006F : {a[26:2] ^ 25'h0123457, 7'b0010011};
  endfunction
  function automatic logic [31:0] nxt(input logic [31:0] pc, input logic [31:0] inst);
`ifdef JAL_PREDICT_EN
    int o;
    if (inst[6:0] == 7'b1101111) begin
      o = int'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      if (inst[31]) o -= 2097152;
      return pc + 32'(o);
    end
`endif
    return pc + 32'd4;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rdy = 1'b1;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_inst = 32'h0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
    rst = 1'b0;
    q.delete();
    exp_fetch = 32'h0;
    pending = 1'b0;
    stale = 1'b0;
    prev_hold = 1'b0;
    prev_redir = 1'b0;
    prev_frozen = 1'b0;
  endtask
  task automatic tick(input bit r, input bit rq, input bit ordy, input bit rd, input logic [31:0] rpc);
    bit acc, resp, pop;
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_pc", bus.out_pc, q[0].pc);
      chk("out_inst", bus.out_inst, q[0].inst);
      chk("out_pred_pc", bus.out_pred_pc, q[0].pred);
    end
    if (q.size() == 4) chk("full_no_req", 32'(bus.mem_req_valid), 32'h0);
    if (pending) chk("one_outstanding", 32'(bus.mem_req_valid), 32'h0);
    if (prev_hold) begin
      chk("req_hold_valid", 32'(bus.mem_req_valid), 32'h1);
      chk("req_hold_addr", bus.mem_req_addr, prev_ra);
    end
    if (prev_redir) chk("redir_no_req", 32'(bus.mem_req_valid), 32'h0);
    if (prev_frozen) begin
      chk("frz_out_valid", 32'(bus.out_valid), 32'(prev_ov));
      chk("frz_req_valid", 32'(bus.mem_req_valid), 32'(prev_rv));
      chk("frz_req_addr", bus.mem_req_addr, prev_ra);
      chk("frz_out_pc", bus.out_pc, prev_pc);
      chk("frz_out_inst", bus.out_inst, prev_inst);
      chk("frz_out_pred", bus.out_pred_pc, prev_pred);
    end
    prev_ov = bus.out_valid;
    prev_rv = bus.mem_req_valid;
    prev_pc = bus.out_pc;
    prev_inst = bus.out_inst;
    prev_pred = bus.out_pred_pc;
    prev_ra = bus.mem_req_addr;
    rdy = r;
    bus.mem_req_ready = rq;
    bus.out_ready = ordy;
    bus.redirect_valid = rd;
    bus.redirect_pc = rpc;
    bus.mem_resp_valid = pending && lat == 0;
    bus.mem_resp_inst = pending ? mem_word(pend_addr) : 32'h0;
    acc = bus.mem_req_valid && rq;
    resp = bus.mem_resp_valid;
    pop = ordy && q.size() != 0;
    prev_hold = r && bus.mem_req_valid && !rq && !rd;
    prev_redir = r && rd;
    prev_frozen = !r;
    if (r) begin
      if (rd) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (resp && !stale) begin
          q.push_back('{pc: pend_addr, inst: mem_word(pend_addr), pred: nxt(pend_addr, mem_word(pend_addr))});
          exp_fetch = nxt(pend_addr, mem_word(pend_addr));
        end
      end
      if (resp) pending = 1'b0;
      else if (pending && lat > 0) lat--;
      if (acc) begin
        chk("req_addr", bus.mem_req_addr, exp_fetch);
        pending = 1'b1;
        pend_addr = bus.mem_req_addr;
        lat = $urandom_range(lat_hi, lat_lo);
        stale = rd;
      end else if (rd) stale = 1'b1;
      if (rd) exp_fetch = rpc & ~32'h3;
    end
  endtask
  initial begin
    logic [31:0] rpc;
    lat_lo = 0;
    lat_hi = 0;
    do_reset();
    tick(1, 1, 1, 0, 0);
    chk("first_req_valid", 32'(bus.mem_req_valid), 32'h1);
    chk("first_req_addr", bus.mem_req_addr, 32'h0);
    repeat (12) tick(1, 1, 1, 0, 0);
    do_reset();
    repeat (20) tick(1, 1, 0, 0, 0);
    chk("fill_no_req", 32'(bus.mem_req_valid), 32'h0);
    chk("fill_head_pc", bus.out_pc, 32'h0);
    repeat (12) tick(1, 1, 1, 0, 0);
    do_reset();
    lat_lo = 2;
    lat_hi = 2;
    repeat (3) tick(1, 1, 1, 0, 0);
    for (int i = 0; i < 20 && !(pending && !stale && pend_addr == 32'h8); i++) tick(1, 1, 1, 0, 0);
    chk("c_wait_at_8", pend_addr, 32'h8);
    tick(1, 1, 1, 1, 32'h103);
    lat_lo = 0;
    lat_hi = 0;
    for (int i = 0; i < 10 && !bus.mem_req_valid; i++) tick(1, 1, 1, 0, 0);
    chk("redir_req_addr", bus.mem_req_addr, 32'h100);
    repeat (8) tick(1, 1, 1, 0, 0);
    do_reset();
    for (int i = 0; i < 30 && !(pending && lat == 0 && q.size() != 0); i++) tick(1, 1, 0, 0, 0);
    tick(1, 1, 1, 1, 32'h200);
    tick(1, 1, 1, 0, 0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < 10 && !bus.mem_req_valid; i++) tick(1, 1, 1, 0, 0);
    chk("flush_req_addr", bus.mem_req_addr, 32'h200);
    do_reset();
    repeat (6) tick(1, 0, 1, 0, 0);
    lat_lo = 2;
    lat_hi = 2;
    for (int i = 0; i < 10 && !pending; i++) tick(1, 1, 1, 0, 0);
    repeat (3) tick(0, 1, 1, 0, 0);
    lat_lo = 0;
    lat_hi = 0;
    repeat (10) tick(1, 1, 1, 0, 0);
    do_reset();
    for (int i = 0; i < 80 && !(bus.out_valid && bus.out_pc == 32'h20); i++) tick(1, 1, 1, 0, 0);
    chk("jal_head_pc", bus.out_pc, 32'h20);
`ifdef JAL_PREDICT_EN
    chk("jal_pred_pc", bus.out_pred_pc, 32'h30);
`else
    chk("jal_pred_pc", bus.out_pred_pc, 32'h24);
`endif
    repeat (12) tick(1, 1, 1, 0, 0);
    do_reset();
    lat_lo = 0;
    lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      tick($urandom_range(9) != 0, $urandom_range(1) != 0, $urandom_range(4) < 3, $urandom_range(32) == 0, rpc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
